io_port_bridge: RTL and testbench

- Sits outside the datapath, on the far side of the OUTPORT and INPORT registers.
- Tx path: captures each word the CPU writes to OUTPORT (OUTPORTin strobe) into a FIFO and hands it to an external consumer over a valid/ready handshake.
- Rx path: accepts words from an external producer over valid/ready, holds each one on INPORT_data_in, and releases it when the CPU reads INPORT (INPORTout strobe).

---
 rtl/io_port_bridge.sv | 116 +++++++++++
 tb/tb_io_port_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// Bridges the CPU OUTPORT/INPORT registers to external valid/ready streams.
// Tx words are queued in a small FIFO; Rx words are held one at a time until the CPU reads them.
module io_port_bridge #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     OUTPORTin,
    input  logic [WIDTH-1:0]         OUTPORT_data_out,
    output logic                     tx_valid,
    output logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_overflow,
    input  logic                     rx_valid,
    input  logic [WIDTH-1:0]         rx_data,
    output logic                     rx_ready,
    output logic [WIDTH-1:0]         INPORT_data_in,
    output logic                     rx_full,
    input  logic                     INPORTout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             capture_pending;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    rx_state_t        rx_state;

    assign tx_valid = (tx_count != '0);
    assign full     = (tx_count == CW'(DEPTH));
    assign pop      = tx_valid && tx_ready;
    assign push     = capture_pending;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);
    assign tx_data  = mem[rd_ptr];

    // OUTPORT only holds the new word one cycle after its load strobe.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            capture_pending <= 1'b0;
        end else begin
            capture_pending <= OUTPORTin;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && push_ok) begin
            mem[wr_ptr] <= OUTPORT_data_out;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (push && full && !pop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Release and accept never share a cycle, so accepted words are at least two cycles apart.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rx_state       <= RX_EMPTY;
            rx_full        <= 1'b0;
            INPORT_data_in <= '0;
        end else begin
            case (rx_state)
                RX_EMPTY: begin
                    if (rx_valid) begin
                        INPORT_data_in <= rx_data;
                        rx_full        <= 1'b1;
                        rx_state       <= RX_FULL;
                    end
                end
                RX_FULL: begin
                    if (INPORTout) begin
                        rx_full  <= 1'b0;
                        rx_state <= RX_EMPTY;
                    end
                end
            endcase
        end
    end

    assign rx_ready = Reset && (rx_state == RX_EMPTY);

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed and randomized checks of io_port_bridge against a queue-based reference model.
module tb_io_port_bridge;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             Clock;
    logic             Reset;
    logic             OUTPORTin;
    logic [WIDTH-1:0] OUTPORT_data_out;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [CW-1:0]    tx_count;
    logic             tx_overflow;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic [WIDTH-1:0] INPORT_data_in;
    logic             rx_full;
    logic             INPORTout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_queue[$];
    bit               m_pending;
    bit               m_overflow;
    bit               m_rx_full;
    logic [WIDTH-1:0] m_rx_word;

    io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .OUTPORTin        (OUTPORTin),
        .OUTPORT_data_out (OUTPORT_data_out),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .tx_count         (tx_count),
        .tx_overflow      (tx_overflow),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .INPORT_data_in   (INPORT_data_in),
        .rx_full          (rx_full),
        .INPORTout        (INPORTout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check("tx_valid", WIDTH'(tx_valid), WIDTH'(m_queue.size() != 0));
        check("tx_count", WIDTH'(tx_count), WIDTH'(m_queue.size()));
        if (m_queue.size() != 0) begin
            check("tx_data", tx_data, m_queue[0]);
        end
        check("tx_overflow", WIDTH'(tx_overflow), WIDTH'(m_overflow));
        check("rx_full", WIDTH'(rx_full), WIDTH'(m_rx_full));
        check("rx_ready", WIDTH'(rx_ready), WIDTH'(!m_rx_full && Reset));
        check("INPORT_data_in", INPORT_data_in, m_rx_word);
    endtask

    // Drives one cycle of inputs, advances the model across the rising edge, then checks.
    task automatic applyStimulus(input logic rst, input logic strobe, input logic [WIDTH-1:0] odata,
                                 input logic ready, input logic rv, input logic [WIDTH-1:0] rd,
                                 input logic rd_strobe);
        bit do_pop;
        Reset            = rst;
        OUTPORTin        = strobe;
        OUTPORT_data_out = odata;
        tx_ready         = ready;
        rx_valid         = rv;
        rx_data          = rd;
        INPORTout        = rd_strobe;
        @(posedge Clock);
        if (!rst) begin
            m_queue.delete();
            m_pending  = 0;
            m_overflow = 0;
            m_rx_full  = 0;
            m_rx_word  = '0;
        end else begin
            do_pop = (m_queue.size() != 0) && ready;
            if (m_pending && m_queue.size() == DEPTH && !do_pop) begin
                m_overflow = 1;
            end else begin
                if (do_pop) void'(m_queue.pop_front());
                if (m_pending) m_queue.push_back(odata);
            end
            m_pending = strobe;
            if (!m_rx_full && rv) begin
                m_rx_full = 1;
                m_rx_word = rd;
            end else if (m_rx_full && rd_strobe) begin
                m_rx_full = 0;
            end
        end
        @(negedge Clock);
        checkOutput();
    endtask

    task automatic idle(input logic ready);
        applyStimulus(1'b1, 1'b0, $urandom, ready, 1'b0, $urandom, 1'b0);
    endtask

    initial begin
        Reset = 1'b0; OUTPORTin = 1'b0; OUTPORT_data_out = '0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = '0; INPORTout = 1'b0;
        m_pending = 0; m_overflow = 0; m_rx_full = 0; m_rx_word = '0;

        $display("[TB] reset and single Tx word");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, '0, 1'b0);
        check("tx_data_AA", tx_data, 32'h0000_00AA);
        idle(1'b1);
        check("tx_count_empty", WIDTH'(tx_count), '0);

        $display("[TB] overflow with five strobes");
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, '0, 1'b0);
        check("overflow_count", WIDTH'(tx_count), 32'd4);
        check("overflow_flag", WIDTH'(tx_overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", tx_data, WIDTH'(i));
            idle(1'b1);
        end
        check("overflow_sticky", WIDTH'(tx_overflow), 32'd1);

        $display("[TB] push and pop while full");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, WIDTH'(i * 16), 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd64, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h55, 1'b1, 1'b0, '0, 1'b0);
        check("full_pushpop_count", WIDTH'(tx_count), 32'd4);
        check("full_pushpop_ovf", WIDTH'(tx_overflow), 32'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("fifth_word", tx_data, 32'h55);
        idle(1'b1);

        $display("[TB] Rx holding register");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("rx_word", INPORT_data_in, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h1234, 1'b0);
        check("rx_not_replaced", INPORT_data_in, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h1234, 1'b1);
        check("rx_released_hold", INPORT_data_in, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h1234, 1'b0);
        check("rx_second_word", INPORT_data_in, 32'h1234);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("rx_empty_read", INPORT_data_in, 32'h1234);

        $display("[TB] reset with buffered traffic");
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hA3, 1'b0, 1'b0, '0, 1'b0);
        check("pre_reset_count", WIDTH'(tx_count), 32'd3);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h7777, 1'b0);
        check("reset_rx_ready", WIDTH'(rx_ready), 32'd0);
        check("reset_inport", INPORT_data_in, '0);
        idle(1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 1)), $urandom,
                          logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)), $urandom,
                          logic'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
